nerv_led_ctrl: RTL
==================

# nerv_led_ctrl

Memory-mapped LED peripheral between the NERV data-memory port and the iCEBreaker LED pins (LEDR_N, LEDG_N, LED1..LED5) in the icebreaker top.
- Software writes static on/off, per-LED 8-bit PWM duty and a common blink mask/period.
- The block generates registered, polarity-corrected pin levels.
- The testbench observes its outputs at the top-level LED ports.

## Interface
Parameters:
- BASE_ADDR, 32'h0100_0000: peripheral base. The block decodes addr[31:8] == BASE_ADDR[31:8].
- ACTIVE_LOW_MASK, 7'b0000011: per-LED pin polarity. A set bit means that pin is active-low (LEDR_N, LEDG_N).

Ports (one clock; reset is asynchronous and active-high):
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- dmem_valid, input, 1: CPU data access this cycle.
- dmem_addr, input, 32: byte address, word-aligned.
- dmem_wstrb, input, 4: byte write enables. 0 means read.
- dmem_wdata, input, 32: write data.
- dmem_rdata, output, 32: read data, registered, valid one cycle after the access.
- led, output, 7: pin levels. Bit 0 = LEDR_N, 1 = LEDG_N, 2..6 = LED1..LED5.

## Operation
Register map (offset from BASE_ADDR; unlisted bits and offsets read 0 and ignore writes):
- 0x00 OUT[6:0]: LED enable mask.
- 0x04 PWM_EN[6:0]: per-LED PWM gating.
- 0x08 DUTY0: bytes 0..3 = duty of LED0..3.
- 0x0C DUTY1: bytes 0..2 = duty of LED4..6.
- 0x10 PERIOD[23:0]: blink half-period in cycles.
- 0x14 BLINK_MASK[6:0]: per-LED blink gating.
- 0x18 STATUS (read-only): bit 0 = blink phase, bits [15:8] = PWM counter.

Bus access:
- Select condition: dmem_valid and address match. Writes honour dmem_wstrb per byte.
- Read: dmem_rdata is updated on the next edge with the register value. Otherwise it is updated to 0.

PWM:
- 8-bit free-running counter pwm_cnt, incremented every cycle, wraps 255 -> 0.
- pwm_on[i] = (pwm_cnt < duty[i]). Duty 0 = never on; duty 255 = on 255 of every 256 cycles.

Blink:
- 24-bit down-counter bcnt.
- When PERIOD != 0:
  - if bcnt == 0: reload bcnt to PERIOD-1 and toggle phase;
  - else: decrement bcnt.
- When PERIOD == 0: bcnt is held at 0 and phase is forced to 1.
- Any write touching PERIOD loads bcnt with the new PERIOD-1 (or 0) and sets phase to 1.

Output:
- lvl[i] = OUT[i] & (PWM_EN[i] ? pwm_on[i] : 1) & (BLINK_MASK[i] ? phase : 1).
- led[i] <= lvl[i] ^ ACTIVE_LOW_MASK[i], registered.

## Timing
- Reset values:
  - all registers 0;
  - pwm_cnt 0, bcnt 0, phase 1;
  - dmem_rdata 0;
  - led = ACTIVE_LOW_MASK (all LEDs dark).
- Reset may assert at any time. It clears state immediately and drives led dark in the same instant, with no clock required.
- Write latency: a write sampled at edge N updates the register at edge N. led reflects the write at edge N+1.
- Read latency: 1 cycle. A read at edge N returns data valid after edge N.
- Simultaneous read and write to the same address in one access is not possible (wstrb != 0 means write). A read in the cycle after a write returns the new value.
- Blink wrap: a single toggle occurs exactly PERIOD cycles after the previous toggle. PERIOD = 1 gives a toggle every cycle.
- PWM wrap: pwm_cnt 255 -> 0. Duty comparison uses the current pwm_cnt; the registered output lags by one cycle.
- Partial-strobe writes to DUTY registers update only the selected LED bytes.

## Structure
- Package nerv_led_pkg holds:
  - register offset localparams (OFS_OUT .. OFS_STATUS);
  - NLEDS = 7;
  - LED index constants (LED_R = 0, LED_G = 1, LED1 = 2 ..).
- One sub-module, nerv_led_pwm: holds pwm_cnt and produces pwm_on[6:0] from the seven duty bytes.
- Register file, blink counter and output stage stay in nerv_led_ctrl.
- The icebreaker top instantiates the block and wires led[0..6] directly to LEDR_N, LEDG_N, LED1..LED5.

## Test plan
- Reset check: assert reset mid-run with OUT = 7'h7F -> led = 7'b0000011 immediately. All reads return 0 after release.
- Static write: write OUT = 7'h05 at cycle N -> led = 7'b0000110 from edge N+1 (red pin low, LED1 high). A read of 0x00 at N+1 returns 0x05.
- PWM: set OUT = 7'h04, PWM_EN = 7'h04, DUTY0 byte 2 = 64 -> LED1 is high for exactly 64 of every 256 cycles.
  - Duty 0 -> never high.
  - Duty 255 -> low exactly 1 cycle per 256.
- Blink: set OUT = 7'h08, BLINK_MASK = 7'h08, PERIOD = 10 -> LED2 toggles every 10 cycles, starting on.
  - Rewrite PERIOD = 3 mid-phase -> phase returns to 1 and toggles resume every 3 cycles.
  - PERIOD = 0 -> LED2 steady on.
- Bus decode and strobes: write wdata 0xAABBCCDD with wstrb 4'b0010 to DUTY0 -> read returns 0x0000CC00. An access at BASE+0x100 or offset 0x1C has no effect and reads 0.
- STATUS: read 0x18 on consecutive cycles -> bits [15:8] increment by 1 per cycle, wrapping 0xFF -> 0x00.

Source files
------------

// File: rtl/nerv_led_pkg.sv
// nerv_led_pkg: shared constants for the NERV LED peripheral.
//   - register offsets (byte offsets from the peripheral base)
//   - LED count and pin index constants (bit positions in led[])
//   - duty_t: one 8-bit PWM duty value
package nerv_led_pkg;

   localparam int NLEDS = 7;

   localparam int LED_R = 0;
   localparam int LED_G = 1;
   localparam int LED1  = 2;
   localparam int LED2  = 3;
   localparam int LED3  = 4;
   localparam int LED4  = 5;
   localparam int LED5  = 6;

   localparam logic [7:0] OFS_OUT    = 8'h00;
   localparam logic [7:0] OFS_PWM_EN = 8'h04;
   localparam logic [7:0] OFS_DUTY0  = 8'h08;
   localparam logic [7:0] OFS_DUTY1  = 8'h0C;
   localparam logic [7:0] OFS_PERIOD = 8'h10;
   localparam logic [7:0] OFS_BLINK  = 8'h14;
   localparam logic [7:0] OFS_STATUS = 8'h18;

   typedef logic [7:0] duty_t;

endpackage

// File: rtl/nerv_led_if.sv
// nerv_led_if: NERV data-memory port as seen by a memory-mapped peripheral.
//   valid  - access this cycle
//   addr   - byte address (word aligned)
//   wstrb  - byte write enables, 0 = read
//   wdata  - write data
//   rdata  - registered read data, valid one cycle after the access
interface nerv_led_if;
   import nerv_led_pkg::*;

   logic        valid;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output valid, addr, wstrb, wdata, input rdata);
   modport slave  (input valid, addr, wstrb, wdata, output rdata);

endinterface

// File: rtl/nerv_led_pwm.sv
// nerv_led_pwm: free-running 8-bit PWM counter and per-LED duty compare.
//   clock, reset - system clock, async active-high reset
//   duty         - seven duty bytes, one per LED
//   pwm_cnt      - current counter value (wraps 255 -> 0)
//   pwm_on       - pwm_cnt < duty[i], combinational from the current count
module nerv_led_pwm
   import nerv_led_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  duty_t [NLEDS-1:0]       duty,
   output logic  [7:0]             pwm_cnt,
   output logic  [NLEDS-1:0]       pwm_on
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) pwm_cnt <= 8'd0;
      else       pwm_cnt <= pwm_cnt + 8'd1;
   end

   // Strict compare: duty 0 never lights, duty 255 leaves one dark cycle.
   always_comb begin
      pwm_on = '0;
      for (int i = 0; i < NLEDS; i++) pwm_on[i] = (pwm_cnt < duty[i]);
   end

endmodule

// File: rtl/nerv_led_ctrl.sv
// nerv_led_ctrl: memory-mapped LED controller for the iCEBreaker LEDs.
//   clock, reset - system clock, async active-high reset
//   dmem         - NERV data-memory slave port (nerv_led_if.slave)
//   led          - registered pin levels, bit 0 LEDR_N, 1 LEDG_N, 2..6 LED1..LED5
// Holds the register file, blink counter and output stage; PWM lives in
// nerv_led_pwm.
module nerv_led_ctrl
   import nerv_led_pkg::*;
#(
   parameter logic [31:0]      BASE_ADDR       = 32'h0100_0000,
   parameter logic [NLEDS-1:0] ACTIVE_LOW_MASK = 7'b0000011
) (
   input  logic             clock,
   input  logic             reset,
   nerv_led_if.slave        dmem,
   output logic [NLEDS-1:0] led
);

   logic             sel, wr, rd, period_touch;
   logic [7:0]       ofs;
   logic [NLEDS-1:0] out_r, pwm_en_r, blink_r;
   logic [31:0]      duty0_r;
   logic [23:0]      duty1_r;
   logic [23:0]      period_r, period_wr;
   logic [23:0]      bcnt;
   logic             phase;
   duty_t [NLEDS-1:0] duty;
   logic [7:0]       pwm_cnt;
   logic [NLEDS-1:0] pwm_on;
   logic [31:0]      rdata_p0, rdata_p1;
   logic [NLEDS-1:0] lvl_p0, led_p1;

   assign sel = dmem.valid && (dmem.addr[31:8] == BASE_ADDR[31:8]);
   assign wr  = sel && (dmem.wstrb != 4'h0);
   assign rd  = sel && (dmem.wstrb == 4'h0);
   assign ofs = dmem.addr[7:0];

   // New PERIOD value after byte strobes; also used to reload bcnt.
   always_comb begin
      period_wr = period_r;
      for (int b = 0; b < 3; b++)
         if (dmem.wstrb[b]) period_wr[8*b +: 8] = dmem.wdata[8*b +: 8];
   end

   assign period_touch = wr && (ofs == OFS_PERIOD) && (|dmem.wstrb[2:0]);

   // ---- register file (write at the sampling edge) ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_r    <= '0;
         pwm_en_r <= '0;
         duty0_r  <= '0;
         duty1_r  <= '0;
         period_r <= '0;
         blink_r  <= '0;
      end else if (wr) begin
         case (ofs)
            OFS_OUT:    if (dmem.wstrb[0]) out_r    <= dmem.wdata[NLEDS-1:0];
            OFS_PWM_EN: if (dmem.wstrb[0]) pwm_en_r <= dmem.wdata[NLEDS-1:0];
            OFS_DUTY0:
               for (int b = 0; b < 4; b++)
                  if (dmem.wstrb[b]) duty0_r[8*b +: 8] <= dmem.wdata[8*b +: 8];
            OFS_DUTY1:
               for (int b = 0; b < 3; b++)
                  if (dmem.wstrb[b]) duty1_r[8*b +: 8] <= dmem.wdata[8*b +: 8];
            OFS_PERIOD: period_r <= period_wr;
            OFS_BLINK:  if (dmem.wstrb[0]) blink_r <= dmem.wdata[NLEDS-1:0];
            default: ;
         endcase
      end
   end

   // ---- blink counter: toggle exactly PERIOD cycles after the last toggle ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bcnt  <= '0;
         phase <= 1'b1;
      end else if (period_touch) begin
         bcnt  <= (period_wr == 24'd0) ? 24'd0 : period_wr - 24'd1;
         phase <= 1'b1;
      end else if (period_r == 24'd0) begin
         bcnt  <= '0;
         phase <= 1'b1;
      end else if (bcnt == 24'd0) begin
         bcnt  <= period_r - 24'd1;
         phase <= ~phase;
      end else begin
         bcnt <= bcnt - 24'd1;
      end
   end

   assign duty[LED_R] = duty0_r[7:0];
   assign duty[LED_G] = duty0_r[15:8];
   assign duty[LED1]  = duty0_r[23:16];
   assign duty[LED2]  = duty0_r[31:24];
   assign duty[LED3]  = duty1_r[7:0];
   assign duty[LED4]  = duty1_r[15:8];
   assign duty[LED5]  = duty1_r[23:16];

   nerv_led_pwm u_pwm (
      .clock   (clock),
      .reset   (reset),
      .duty    (duty),
      .pwm_cnt (pwm_cnt),
      .pwm_on  (pwm_on)
   );

   always_comb begin
      rdata_p0 = 32'h0;
      case (ofs)
         OFS_OUT:    rdata_p0 = {25'h0, out_r};
         OFS_PWM_EN: rdata_p0 = {25'h0, pwm_en_r};
         OFS_DUTY0:  rdata_p0 = duty0_r;
         OFS_DUTY1:  rdata_p0 = {8'h0, duty1_r};
         OFS_PERIOD: rdata_p0 = {8'h0, period_r};
         OFS_BLINK:  rdata_p0 = {25'h0, blink_r};
         OFS_STATUS: rdata_p0 = {16'h0, pwm_cnt, 7'h0, phase};
         default:    rdata_p0 = 32'h0;
      endcase
   end

   // Gating: a clear enable bit passes the LED through unconditionally.
   assign lvl_p0 = out_r & (~pwm_en_r | pwm_on) & (~blink_r | {NLEDS{phase}});

   // ---- p0 -> p1: registered read data and polarity-corrected pins ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdata_p1 <= 32'h0;
         led_p1   <= ACTIVE_LOW_MASK;
      end else begin
         rdata_p1 <= rd ? rdata_p0 : 32'h0;
         led_p1   <= lvl_p0 ^ ACTIVE_LOW_MASK;
      end
   end

   assign dmem.rdata = rdata_p1;
   assign led        = led_p1;

endmodule
